// File: rtl/mprc_locking_router_if.sv
// Inbound grant stream and broadcast outbound bus of the locking router.
// Ports: io_in_* (valid/ready/dest/bits), io_out_* (per-port valid/ready,
// shared bits), io_locked, io_err.
interface mprc_locking_router_if #(
    parameter int N_OUT = 3
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [1:0]       io_in_dest;
    logic [1:0]       io_in_bits_addr_beat;
    logic [1:0]       io_in_bits_client_xact_id;
    logic             io_in_bits_is_builtin_type;
    logic [3:0]       io_in_bits_g_type;
    logic [127:0]     io_in_bits_data;

    logic [N_OUT-1:0] io_out_valid;
    logic [N_OUT-1:0] io_out_ready;
    logic [1:0]       io_out_bits_addr_beat;
    logic [1:0]       io_out_bits_client_xact_id;
    logic             io_out_bits_is_builtin_type;
    logic [3:0]       io_out_bits_g_type;
    logic [127:0]     io_out_bits_data;

    logic             io_locked;
    logic             io_err;

    modport master (
        output io_in_valid, io_in_dest,
        output io_in_bits_addr_beat, io_in_bits_client_xact_id,
        output io_in_bits_is_builtin_type, io_in_bits_g_type,
        output io_in_bits_data,
        output io_out_ready,
        input  io_in_ready, io_out_valid,
        input  io_out_bits_addr_beat, io_out_bits_client_xact_id,
        input  io_out_bits_is_builtin_type, io_out_bits_g_type,
        input  io_out_bits_data,
        input  io_locked, io_err
    );

    modport slave (
        input  io_in_valid, io_in_dest,
        input  io_in_bits_addr_beat, io_in_bits_client_xact_id,
        input  io_in_bits_is_builtin_type, io_in_bits_g_type,
        input  io_in_bits_data,
        input  io_out_ready,
        output io_in_ready, io_out_valid,
        output io_out_bits_addr_beat, io_out_bits_client_xact_id,
        output io_out_bits_is_builtin_type, io_out_bits_g_type,
        output io_out_bits_data,
        output io_locked, io_err
    );
endinterface

// File: rtl/mprc_locking_router.sv
// Locking router: steers grant beats to one of N_OUT consumers, holding the
// destination for a whole data burst; one registered output slot.
// Ports: clk, reset (sync, active-low), bus (mprc_locking_router_if.slave).
// Optional: MPRC_ROUTER_BEAT_CHECK_EN flags addr_beat != beat counter in io_err.
module mprc_locking_router #(
    parameter int N_OUT = 3,
    parameter int BEATS = 4
) (
    input logic                 clk,
    input logic                 reset,
    mprc_locking_router_if.slave bus
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [2:0] NOUT = 3'(N_OUT);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      lock_idx, lock_idx_n;

    logic            full;
    logic            drop;
    logic [1:0]      slot_dest;
    logic [1:0]      s_beat;
    logic [1:0]      s_xact;
    logic            s_builtin;
    logic [3:0]      s_gtype;
    logic [127:0]    s_data;

    logic            locked;
    logic            has_data;
    logic [1:0]      sel;
    logic            sel_bad;
    logic            sel_ready;
    logic            drain;
    logic            fire;
    logic            err;
    logic            err_set;

    assign locked    = (state == BURST);
    assign has_data  = !bus.io_in_bits_is_builtin_type
                     && (bus.io_in_bits_g_type < 4'd3);
    assign sel       = locked ? lock_idx : bus.io_in_dest;
    assign sel_bad   = ({1'b0, sel} >= NOUT);

    // Ready of the port the slot currently targets.
    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (slot_dest == 2'(i)) sel_ready = bus.io_out_ready[i];
        end
    end

    // Dropped beats vacate the slot unconditionally.
    assign drain = full && (drop || sel_ready);
    assign bus.io_in_ready = !full || drain;
    assign fire  = bus.io_in_valid && bus.io_in_ready;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lock_idx_n = lock_idx;
        if (fire) begin
            if (has_data) begin
                cnt_n   = cnt + CW'(1);
                state_n = (cnt_n != '0) ? BURST : IDLE;
                if (!locked) lock_idx_n = bus.io_in_dest;
            end else begin
                // Non-data beat ends any burst (abort if mid-burst).
                state_n = IDLE;
                cnt_n   = '0;
            end
        end
    end

    always_comb begin
        err_set = fire && sel_bad;
`ifdef MPRC_ROUTER_BEAT_CHECK_EN
        if (fire && has_data && (bus.io_in_bits_addr_beat != 2'(cnt)))
            err_set = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lock_idx <= '0;
            full     <= 1'b0;
            drop     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lock_idx <= lock_idx_n;
            if (err_set) err <= 1'b1;
            if (fire) begin
                full <= 1'b1;
                drop <= sel_bad;
            end else if (drain) begin
                full <= 1'b0;
            end
        end
    end

    // Payload needs no reset; it is only observed when full.
    always_ff @(posedge clk) begin
        if (fire) begin
            slot_dest <= sel;
            s_beat    <= bus.io_in_bits_addr_beat;
            s_xact    <= bus.io_in_bits_client_xact_id;
            s_builtin <= bus.io_in_bits_is_builtin_type;
            s_gtype   <= bus.io_in_bits_g_type;
            s_data    <= bus.io_in_bits_data;
        end
    end

    always_comb begin
        bus.io_out_valid = '0;
        for (int i = 0; i < N_OUT; i++) begin
            bus.io_out_valid[i] = full && !drop && (slot_dest == 2'(i));
        end
    end

    assign bus.io_out_bits_addr_beat       = s_beat;
    assign bus.io_out_bits_client_xact_id  = s_xact;
    assign bus.io_out_bits_is_builtin_type = s_builtin;
    assign bus.io_out_bits_g_type          = s_gtype;
    assign bus.io_out_bits_data            = s_data;
    assign bus.io_locked                   = locked;
    assign bus.io_err                      = err;
endmodule

// File: doc/mprc_locking_router.md
Name: mprc_locking_router

Overview:
- Inverse of the client-side locking arbiter: takes one inbound manager-to-client message stream (grant-class, up to 4 beats of 128-bit data) and steers each message to one of N_OUT client-side consumers.
- The destination is sampled on the first beat of a data-carrying message and held (locked) until the last beat, so all beats of a burst land on the same consumer.
- A single registered output stage gives 1-cycle latency with full throughput.

Parameters:
- N_OUT, 3, number of destination ports (2..4).
- BEATS, 4, data beats per data-carrying message (power of 2; counter width log2(BEATS)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- io_in_valid  in  1  inbound beat valid.
- io_in_ready  out  1  inbound beat accepted when valid&ready.
- io_in_dest  in  2  destination index; sampled only when not locked.
- io_in_bits_addr_beat  in  2  beat index.
- io_in_bits_client_xact_id  in  2  client transaction id.
- io_in_bits_is_builtin_type  in  1  built-in message type flag.
- io_in_bits_g_type  in  4  grant type.
- io_in_bits_data  in  128  beat data.
- io_out_valid  out  N_OUT  one-hot valid per destination.
- io_out_ready  in  N_OUT  per-destination ready.
- io_out_bits_*  out  same widths as io_in_bits_*  bus shared by all ports (broadcast); only the valid bit is per port.
- io_locked  out  1  burst in progress.
- io_err  out  1  sticky error flag.

Behaviour:
- Reset (reset==0 at clk edge): slot empty, locked=0, lock_idx=0, cnt=0, io_err=0. io_out_valid=0, io_locked=0, io_in_ready=1. Output bus contents are don't-care.
- has_data = !is_builtin_type && g_type<3.
- sel = locked ? lock_idx : io_in_dest.
- Output slot holds {bits, dest, drop}. io_out_valid[i] = full && !drop && dest==i.
  - Slot drains when the selected io_out_ready is high, or immediately in the next cycle if drop=1.
  - io_in_ready = !full || drain. Load and drain in the same cycle is allowed, giving 1 beat/cycle.
- Latency: a beat accepted in cycle t is presented in cycle t+1.
- Out-of-range destination (sel>=N_OUT): the beat is accepted with drop=1 and never presented on any port; io_err set.
  - If this happens on the first beat of a burst, lock_idx is still captured, so the whole burst is dropped.
- Lock FSM, applied on each accept (fire):
  - has_data: cnt <= cnt+1 (wraps mod BEATS); locked <= (cnt+1 != 0). If !locked, lock_idx <= io_in_dest.
  - !has_data: locked <= 0, cnt <= 0. The beat is routed by sel (lock_idx if it arrives mid-burst); arriving mid-burst is a protocol abort.
- Resulting states: IDLE (locked=0) -> BURST (after beat 0 of a data message) -> IDLE after beat BEATS-1 or after an abort.
- Output port back-pressure stalls only the inbound stream; there is no reordering.
- Reset asserted mid-burst: locked, cnt and slot are cleared; a partially delivered burst is abandoned.
- io_locked = locked.

Optional Feature:
- MPRC_ROUTER_BEAT_CHECK_EN defined: on every accepted has_data beat, io_in_bits_addr_beat!=cnt sets io_err. The beat is still routed normally.
- Undefined: addr_beat is passed through unchecked; io_err is set only by an out-of-range destination.

Test Plan:
- Single beat: is_builtin=1, g_type=3, dest=1, out_ready=3'b111 -> io_out_valid=3'b010 one cycle later with bits unchanged; io_locked stays 0.
- 4-beat burst: g_type=1, is_builtin=0, dest=2 on beat 0 and dest=0 on beats 1-3 -> all 4 beats on port 2 on consecutive cycles; io_locked=1 after beat 0 and 0 after beat 3.
- Back-pressure: out_ready[2]=0 for 3 cycles mid-burst -> io_in_ready=0 while the slot is full, no beat lost or duplicated, burst completes on port 2.
- Abort: non-data beat after 2 data beats -> forwarded to the locked port; locked=0 and cnt=0; the next data burst locks its own dest.
- dest=3 with N_OUT=3 -> beat consumed, no io_out_valid, io_err=1 until reset=0. Under MPRC_ROUTER_BEAT_CHECK_EN, addr_beat sequence 0,1,3,3 -> io_err=1.
- Assert reset=0 after beat 1 of a burst -> io_out_valid=0, io_locked=0, io_in_ready=1 next cycle; a new burst to dest=0 routes correctly.
